// File: rtl/hall_decoder_if.sv
// Hall decoder signal bundle: raw sensor input plus decoded position/speed status.
// Optional HALL_REV_PERIOD_EN adds the per-revolution period sum.
interface hall_decoder_if #(
    parameter int unsigned PERIOD_WIDTH = 20
);
    logic [2:0]              HS;
    logic [2:0]              sector;
    logic                    sector_valid;
    logic                    step_pulse;
    logic                    direction;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    locked;
    logic                    stalled;
    logic                    hall_error;
`ifdef HALL_REV_PERIOD_EN
    logic [PERIOD_WIDTH+2:0] rev_period;
    logic                    rev_valid;

    modport master (
        output HS,
        input  sector, sector_valid, step_pulse, direction, period, period_valid,
        input  locked, stalled, hall_error, rev_period, rev_valid
    );
    modport slave (
        input  HS,
        output sector, sector_valid, step_pulse, direction, period, period_valid,
        output locked, stalled, hall_error, rev_period, rev_valid
    );
`else
    modport master (
        output HS,
        input  sector, sector_valid, step_pulse, direction, period, period_valid,
        input  locked, stalled, hall_error
    );
    modport slave (
        input  HS,
        output sector, sector_valid, step_pulse, direction, period, period_valid,
        output locked, stalled, hall_error
    );
`endif
endinterface

// File: rtl/hall_decoder.sv
// Hall sensor synchronizer, deglitch filter, sector decoder and speed/lock tracker.
// Define HALL_REV_PERIOD_EN to add the rolling sum of the last six step periods.
module hall_decoder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned PERIOD_WIDTH  = 20,
    parameter int unsigned STALL_CYCLES  = 270000,
    parameter int unsigned LOCK_STEPS    = 6
) (
    input logic           clk,
    input logic           rst,
    hall_decoder_if.slave hall_io
);
    localparam int unsigned FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int unsigned CCW = $clog2(LOCK_STEPS + 1);
    localparam logic [FCW-1:0]          FiltLast  = FCW'(FILTER_CYCLES - 1);
    localparam logic [CCW-1:0]          LockMax   = CCW'(LOCK_STEPS);
    localparam logic [PERIOD_WIDTH-1:0] PMax      = '1;
    localparam logic [PERIOD_WIDTH-1:0] StallLast = PERIOD_WIDTH'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {StStalled, StSeeking, StLocked, StFault} state_e;

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  synced;
    logic [2:0]                  cand_q, cand_d, filt_q, filt_d;
    logic [FCW-1:0]              fcnt_q, fcnt_d;
    logic                        accept;

    logic [2:0]              sector_q, sector_d;
    logic                    sv_q, sv_d, step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d, pcnt_q, pcnt_d;
    logic                    pv_q, pv_d, seen_q, seen_d;
    logic [CCW-1:0]          consec_q, consec_d;
    state_e                  state_q, state_d;

    logic [2:0] new_sec, delta;
    logic       new_ok, fwd;

    function automatic logic [3:0] decode(input logic [2:0] code);
        unique case (code)
            3'b001:  decode = {1'b1, 3'd0};
            3'b011:  decode = {1'b1, 3'd1};
            3'b010:  decode = {1'b1, 3'd2};
            3'b110:  decode = {1'b1, 3'd3};
            3'b100:  decode = {1'b1, 3'd4};
            3'b101:  decode = {1'b1, 3'd5};
            default: decode = 4'b0000;
        endcase
    endfunction

    assign synced = sync_q[SYNC_STAGES-1];

    // Candidate tracks the synced code; it is accepted once stable for FILTER_CYCLES cycles.
    always_comb begin
        cand_d = cand_q;
        fcnt_d = fcnt_q;
        accept = 1'b0;
        if (synced != cand_q) begin
            cand_d = synced;
            fcnt_d = '0;
        end else if (cand_q != filt_q) begin
            if (fcnt_q == FiltLast) accept = 1'b1;
            else                    fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign {new_ok, new_sec} = decode(cand_q);
    // Modulo-6 distance in 3-bit arithmetic.
    assign delta = (new_sec >= sector_q) ? (new_sec - sector_q) : (new_sec + 3'd6 - sector_q);
    assign fwd   = (delta == 3'd1);

    always_comb begin
        sector_d = sector_q;
        sv_d     = sv_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        period_d = period_q;
        pv_d     = pv_q;
        err_d    = 1'b0;
        state_d  = state_q;
        consec_d = consec_q;
        seen_d   = seen_q;
        filt_d   = filt_q;
        pcnt_d   = (pcnt_q == PMax) ? pcnt_q : pcnt_q + 1'b1;
        if (accept) begin
            filt_d = cand_q;
            if (!new_ok) begin
                err_d    = 1'b1;
                sv_d     = 1'b0;
                state_d  = StFault;
                pv_d     = 1'b0;
                seen_d   = 1'b0;
                consec_d = '0;
            end else if (!sv_q) begin
                sector_d = new_sec;
                sv_d     = 1'b1;
                pcnt_d   = '0;
                pv_d     = 1'b0;
                seen_d   = 1'b0;
                if (state_q == StFault) begin
                    state_d  = StSeeking;
                    consec_d = '0;
                end
            end else if (delta == 3'd1 || delta == 3'd5) begin
                sector_d = new_sec;
                step_d   = 1'b1;
                dir_d    = fwd;
                pcnt_d   = '0;
                period_d = (pcnt_q == PMax) ? PMax : pcnt_q + 1'b1;
                pv_d     = seen_q;
                seen_d   = 1'b1;
                if ((state_q == StSeeking || state_q == StLocked) && fwd == dir_q) begin
                    consec_d = (consec_q == LockMax) ? consec_q : consec_q + 1'b1;
                end else begin
                    consec_d = CCW'(1);
                end
                state_d = (consec_d == LockMax) ? StLocked : StSeeking;
            end else begin
                sector_d = new_sec;
                err_d    = 1'b1;
                consec_d = '0;
                pcnt_d   = '0;
                pv_d     = 1'b0;
                seen_d   = 1'b0;
                if (state_q == StLocked) state_d = StSeeking;
            end
        end else if (pcnt_q == StallLast) begin
            state_d  = StStalled;
            pv_d     = 1'b0;
            seen_d   = 1'b0;
            consec_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cand_q   <= '0;
            filt_q   <= '0;
            fcnt_q   <= '0;
            sector_q <= '0;
            sv_q     <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b1;
            period_q <= '0;
            pcnt_q   <= '0;
            pv_q     <= 1'b0;
            seen_q   <= 1'b0;
            err_q    <= 1'b0;
            consec_q <= '0;
            state_q  <= StStalled;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], hall_io.HS};
            cand_q   <= cand_d;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            sector_q <= sector_d;
            sv_q     <= sv_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
            pv_q     <= pv_d;
            seen_q   <= seen_d;
            err_q    <= err_d;
            consec_q <= consec_d;
            state_q  <= state_d;
        end
    end

    assign hall_io.sector       = sector_q;
    assign hall_io.sector_valid = sv_q;
    assign hall_io.step_pulse   = step_q;
    assign hall_io.direction    = dir_q;
    assign hall_io.period       = period_q;
    assign hall_io.period_valid = pv_q;
    assign hall_io.locked       = (state_q == StLocked);
    assign hall_io.stalled      = (state_q == StStalled);
    assign hall_io.hall_error   = err_q;

`ifdef HALL_REV_PERIOD_EN
    logic [5:0][PERIOD_WIDTH-1:0] hist_q, hist_d;
    logic [PERIOD_WIDTH+2:0]      rsum_q, rsum_d;
    logic [2:0]                   rcnt_q, rcnt_d;

    // History follows period_valid: cleared whenever it drops, fed by every valid period.
    always_comb begin
        hist_d = hist_q;
        rsum_d = rsum_q;
        rcnt_d = rcnt_q;
        if (!pv_d) begin
            hist_d = '0;
            rsum_d = '0;
            rcnt_d = '0;
        end else if (step_d) begin
            hist_d = {hist_q[4:0], period_d};
            rsum_d = rsum_q + {3'b000, period_d} - {3'b000, hist_q[5]};
            rcnt_d = (rcnt_q == 3'd6) ? rcnt_q : rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            rsum_q <= '0;
            rcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            rsum_q <= rsum_d;
            rcnt_q <= rcnt_d;
        end
    end

    assign hall_io.rev_period = rsum_q;
    assign hall_io.rev_valid  = (rcnt_q == 3'd6);
`endif
endmodule

// File: tb/tb_hall_decoder.sv
// Directed bench for hall_decoder: expected outcomes queued at drive time, popped on DUT event.
module tb_hall_decoder;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned FILT  = 16;
    localparam int unsigned PW    = 20;
    localparam int unsigned STALL = 5000;
    localparam int unsigned LOCK  = 6;
    localparam int unsigned LAT   = SYNC + FILT + 1;

    typedef struct packed {
        logic [2:0]    sector;
        logic          sv;
        logic          step;
        logic          err;
        logic          dir;
        logic          pv;
        logic          chkp;
        logic [PW-1:0] period;
        logic          locked;
        logic          stalled;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hall_decoder_if #(.PERIOD_WIDTH(PW)) hif ();

    hall_decoder #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .PERIOD_WIDTH  (PW),
        .STALL_CYCLES  (STALL),
        .LOCK_STEPS    (LOCK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hall_io (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] sector, input logic sv, input logic step,
                                input logic err, input logic dir, input logic pv,
                                input logic chkp, input logic locked, input logic stalled);
        exp_t e;
        e.sector  = sector;
        e.sv      = sv;
        e.step    = step;
        e.err     = err;
        e.dir     = dir;
        e.pv      = pv;
        e.chkp    = chkp;
        e.period  = PW'(1000);
        e.locked  = locked;
        e.stalled = stalled;
        return e;
    endfunction

    // Drive a code at a negedge, wait for its accepted-change event, compare, then hold.
    task automatic apply(input logic [2:0] code, input exp_t e, input int hold);
        int   n;
        logic sv0;
        bit   seen;
        exp_t x;
        sv0 = hif.sector_valid;
        hif.HS = code;
        sb.push_back(e);
        n = 0;
        seen = 0;
        while (!seen && n < 4 * LAT) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (hif.step_pulse || hif.hall_error || hif.sector_valid != sv0) seen = 1;
        end
        x = sb.pop_front();
        chk($sformatf("latency_%b", code), 32'(n), 32'(LAT));
        chk($sformatf("sector_%b", code), 32'(hif.sector), 32'(x.sector));
        chk($sformatf("sector_valid_%b", code), 32'(hif.sector_valid), 32'(x.sv));
        chk($sformatf("step_pulse_%b", code), 32'(hif.step_pulse), 32'(x.step));
        chk($sformatf("hall_error_%b", code), 32'(hif.hall_error), 32'(x.err));
        chk($sformatf("direction_%b", code), 32'(hif.direction), 32'(x.dir));
        chk($sformatf("period_valid_%b", code), 32'(hif.period_valid), 32'(x.pv));
        if (x.chkp) chk($sformatf("period_%b", code), 32'(hif.period), 32'(x.period));
        chk($sformatf("locked_%b", code), 32'(hif.locked), 32'(x.locked));
        chk($sformatf("stalled_%b", code), 32'(hif.stalled), 32'(x.stalled));
        @(negedge clk);
        chk($sformatf("pulse_width_%b", code), 32'({hif.step_pulse, hif.hall_error}), 32'(0));
        repeat (hold - n - 1) @(negedge clk);
    endtask

    initial begin
        logic [2:0] fwd_codes [6];
        int         cnt;
        logic       bad;
        fwd_codes = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};

        hif.HS = 3'b001;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sector", 32'(hif.sector), 32'(0));
        chk("rst_sector_valid", 32'(hif.sector_valid), 32'(0));
        chk("rst_step_pulse", 32'(hif.step_pulse), 32'(0));
        chk("rst_direction", 32'(hif.direction), 32'(1));
        chk("rst_period", 32'(hif.period), 32'(0));
        chk("rst_period_valid", 32'(hif.period_valid), 32'(0));
        chk("rst_locked", 32'(hif.locked), 32'(0));
        chk("rst_stalled", 32'(hif.stalled), 32'(1));
        chk("rst_hall_error", 32'(hif.hall_error), 32'(0));
        rst = 1'b0;

        apply(3'b001, mk(3'd0, 1, 0, 0, 1, 0, 0, 0, 1), 40);

        // Glitches shorter than the filter window must leave every output untouched.
        for (int g = 1; g <= 15; g++) begin
            bad = 1'b0;
            hif.HS = 3'b111;
            repeat (g) begin
                @(negedge clk);
                if (hif.step_pulse || hif.hall_error || hif.sector != 3'd0 || !hif.sector_valid)
                    bad = 1'b1;
            end
            hif.HS = 3'b001;
            repeat (25) begin
                @(negedge clk);
                if (hif.step_pulse || hif.hall_error || hif.sector != 3'd0 || !hif.sector_valid)
                    bad = 1'b1;
            end
            chk($sformatf("glitch_%0d", g), 32'(bad), 32'(0));
        end

        for (int i = 0; i < 6; i++) begin
            apply(fwd_codes[i], mk(3'((i + 1) % 6), 1, 1, 0, 1, (i >= 1), (i >= 1), (i == 5), 0),
                  1000);
        end
        apply(3'b011, mk(3'd1, 1, 1, 0, 1, 1, 1, 1, 0), 1000);
        apply(3'b010, mk(3'd2, 1, 1, 0, 1, 1, 1, 1, 0), 1000);
        apply(3'b110, mk(3'd3, 1, 1, 0, 1, 1, 1, 1, 0), 1000);
`ifdef HALL_REV_PERIOD_EN
        chk("rev_valid", 32'(hif.rev_valid), 32'(1));
        chk("rev_period", 32'(hif.rev_period), 32'(6000));
`endif

        apply(3'b010, mk(3'd2, 1, 1, 0, 0, 1, 1, 0, 0), 1000);
        apply(3'b011, mk(3'd1, 1, 1, 0, 0, 1, 1, 0, 0), 1000);
        apply(3'b100, mk(3'd4, 1, 0, 1, 0, 0, 0, 0, 0), 1000);
`ifdef HALL_REV_PERIOD_EN
        chk("rev_valid_skip", 32'(hif.rev_valid), 32'(0));
`endif
        apply(3'b000, mk(3'd4, 0, 0, 1, 0, 0, 0, 0, 0), 1000);
        apply(3'b010, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 0), LAT + 1);

        // Stall fires STALL cycles after the counter was cleared by the load above.
        cnt = 1;
        while (!hif.stalled && cnt < 6000) begin
            @(negedge clk);
            cnt++;
        end
        chk("stall_cycles", 32'(cnt), 32'(STALL));
        chk("stall_locked", 32'(hif.locked), 32'(0));
        chk("stall_period_valid", 32'(hif.period_valid), 32'(0));
        chk("stall_sector", 32'(hif.sector), 32'(2));
        chk("stall_sector_valid", 32'(hif.sector_valid), 32'(1));
        repeat (1000) @(negedge clk);
        chk("stall_hold", 32'(hif.stalled), 32'(1));

        apply(3'b110, mk(3'd3, 1, 1, 0, 1, 0, 0, 0, 0), 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
